// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock, one round key per 4 words.
// Optional round-key store with registered read port under `define AES_KS_STORE_EN.
module aes_key_schedule_seq #(
   parameter int unsigned KEY_W  = 256,
   parameter int unsigned MAX_RK = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        key_len,
   input  logic [KEY_W-1:0]  key,
   output logic              busy,
   output logic              rk_valid,
   output logic [3:0]        rk_round,
   output logic [127:0]      rk,
   output logic              done,
   output logic              err,
   input  logic [3:0]        rd_addr,
   output logic [127:0]      rd_key
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned WIN_N  = 8;

   // AES forward S-box, entry x at bits {~x,3'b000} +: 8 (entry 0 is the MSB byte)
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [255:0]      key_q, key_d;
   logic [1:0]        len_q, len_d;
   logic [5:0]        i_q, i_d;
   logic [2:0]        j_q, j_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [WORD_W-1:0] win_q [WIN_N];
   logic [WORD_W-1:0] win_d [WIN_N];
   logic              busy_d, rk_valid_d, done_d, err_d;
   logic [3:0]        rk_round_d;
   logic [127:0]      rk_d;

   logic [5:0]        nk, last_idx;
   logic [WORD_W-1:0] rot_w, sub_in, sub_out, t_w, key_w, w_new;

   // Key-length decode; last_idx is the index of the final schedule word (4*Nr+3)
   always_comb begin
      nk       = 6'd4;
      last_idx = 6'd43;
      case (len_q)
         2'b01:   begin nk = 6'd6; last_idx = 6'd51; end
         2'b10:   begin nk = 6'd8; last_idx = 6'd59; end
         default: ;
      endcase
   end

   // Next schedule word w[i]; win_q[0] = w[i-1], win_q[Nk-1] = w[i-Nk]
   always_comb begin
      rot_w   = {win_q[0][23:0], win_q[0][31:24]};
      sub_in  = (j_q == 3'd0) ? rot_w : win_q[0];
      sub_out = sub_word(sub_in);
      if (j_q == 3'd0)
         t_w = sub_out ^ {rcon_q, 24'h000000};
      else if (nk == 6'd8 && j_q == 3'd4)
         t_w = sub_out;
      else
         t_w = win_q[0];
      key_w = key_q[{~i_q[2:0], 5'b00000} +: 32];
      w_new = (i_q < nk) ? key_w : (win_q[3'(nk - 6'd1)] ^ t_w);
   end

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      len_d      = len_q;
      i_d        = i_q;
      j_d        = j_q;
      rcon_d     = rcon_q;
      win_d      = win_q;
      busy_d     = busy;
      rk_valid_d = 1'b0;
      done_d     = 1'b0;
      rk_round_d = rk_round;
      rk_d       = rk;
      err_d      = err;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (key_len == 2'b11) begin
                  err_d = 1'b1;
               end else begin
                  key_d   = key[KEY_W-1 -: 256];
                  len_d   = key_len;
                  i_d     = 6'd0;
                  j_d     = 3'd0;
                  rcon_d  = 8'h01;
                  err_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            win_d[0] = w_new;
            for (int k = 1; k < WIN_N; k++) win_d[k] = win_q[k-1];
            i_d = i_q + 6'd1;
            j_d = (j_q == 3'(nk - 6'd1)) ? 3'd0 : j_q + 3'd1;
            if (i_q >= nk && j_q == 3'd0) rcon_d = xtime(rcon_q);
            // Fourth word of a group completes a round key
            if (i_q[1:0] == 2'b11) begin
               rk_d       = {win_q[2], win_q[1], win_q[0], w_new};
               rk_round_d = i_q[5:2];
               rk_valid_d = 1'b1;
            end
            if (i_q == last_idx) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         key_q    <= '0;
         len_q    <= '0;
         i_q      <= '0;
         j_q      <= '0;
         rcon_q   <= '0;
         for (int k = 0; k < WIN_N; k++) win_q[k] <= '0;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         done     <= 1'b0;
         rk_round <= '0;
         rk       <= '0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         len_q    <= len_d;
         i_q      <= i_d;
         j_q      <= j_d;
         rcon_q   <= rcon_d;
         win_q    <= win_d;
         busy     <= busy_d;
         rk_valid <= rk_valid_d;
         done     <= done_d;
         rk_round <= rk_round_d;
         rk       <= rk_d;
         err      <= err_d;
      end
   end

`ifdef AES_KS_STORE_EN
   logic [127:0] rk_mem [MAX_RK];
   logic [3:0]   nr;

   assign nr = last_idx[5:2];

   // Round-key store for reverse-order reads; addresses beyond Nr read as zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned n = 0; n < MAX_RK; n++) rk_mem[n] <= '0;
         rd_key <= '0;
      end else begin
         if (rk_valid) rk_mem[rk_round] <= rk;
         if (rd_addr <= nr && 32'(rd_addr) < MAX_RK)
            rd_key <= rk_mem[rd_addr];
         else
            rd_key <= '0;
      end
   end
`else
   logic [3:0] rd_addr_unused;

   assign rd_addr_unused = rd_addr ^ 4'(MAX_RK);
   assign rd_key         = '0;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule_seq;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   key_len = 2'b00;
   logic [255:0] key = '0;
   logic [3:0]   rd_addr = 4'd0;
   logic         busy, rk_valid, done, err;
   logic [3:0]   rk_round;
   logic [127:0] rk, rd_key;

   aes_key_schedule_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_len  (key_len),
      .key      (key),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_round (rk_round),
      .rk       (rk),
      .done     (done),
      .err      (err),
      .rd_addr  (rd_addr),
      .rd_key   (rd_key)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int pulses = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int s_cyc = 0;
   int p0 = 0;
   int d0 = 0;
   logic [127:0] cap [16];
   int           cap_cyc [16];

   always @(posedge clk) cyc <= cyc + 1;

   // Record every round-key pulse and done pulse just after the edge that produced it
   always @(posedge clk) begin
      #1;
      if (rk_valid) begin
         cap[rk_round]     = rk;
         cap_cyc[rk_round] = cyc;
         pulses++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Start a run, scramble key/key_len after acceptance, optionally pulse start at loop step poke
   task automatic run_key(input logic [1:0] len, input logic [255:0] k, input int poke);
      @(negedge clk);
      key     = k;
      key_len = len;
      start   = 1'b1;
      s_cyc   = cyc;
      p0      = pulses;
      d0      = done_cnt;
      @(negedge clk);
      start   = 1'b0;
      key     = ~k;
      key_len = ~len;
      for (int n = 1; n < 100 && done_cnt == d0; n++) begin
         @(negedge clk);
         start = (n == poke);
      end
      start = 1'b0;
   endtask

   initial begin
      for (int n = 0; n < 16; n++) begin cap[n] = '0; cap_cyc[n] = -1; end

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_rk", 128'(rk), 128'h0);
      chk("reset_ctl", 128'({busy, rk_valid, done, err, rk_round}), 128'h0);
      rst = 1'b0;

      // AES-128
      run_key(2'b00, KEY128, 0);
      chk("a128_rk0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
      chk("a128_rk1", cap[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      chk("a128_rk10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("a128_lat0", 128'(cap_cyc[0] - s_cyc - 1), 128'd4);
      chk("a128_done_cyc", 128'(done_cyc - s_cyc - 1), 128'd44);
      chk("a128_done_cnt", 128'(done_cnt - d0), 128'd1);
      chk("a128_pulses", 128'(pulses - p0), 128'd11);
      chk("a128_busy_after", 128'(busy), 128'd0);
      repeat (3) @(negedge clk);
      chk("a128_rk_hold", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);

`ifdef AES_KS_STORE_EN
      rd_addr = 4'd10;
      @(negedge clk);
      chk("store_rd10", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      rd_addr = 4'd0;
      @(negedge clk);
      chk("store_rd0", rd_key, 128'h000102030405060708090a0b0c0d0e0f);
      rd_addr = 4'd11;
      @(negedge clk);
      chk("store_rd11", rd_key, 128'h0);
`else
      rd_addr = 4'd10;
      @(negedge clk);
      chk("nostore_rd", rd_key, 128'h0);
`endif

      // AES-192
      run_key(2'b01, KEY192, 0);
      chk("a192_rk0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
      chk("a192_rk1", cap[1], 128'h10111213141516175846f2f95c43f4fe);
      chk("a192_rk12", cap[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
      chk("a192_done_cyc", 128'(done_cyc - s_cyc - 1), 128'd52);
      chk("a192_pulses", 128'(pulses - p0), 128'd13);

      // AES-256
      run_key(2'b10, KEY256, 0);
      chk("a256_rk1", cap[1], 128'h101112131415161718191a1b1c1d1e1f);
      chk("a256_rk14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
      chk("a256_done_cyc", 128'(done_cyc - s_cyc - 1), 128'd60);
      chk("a256_pulses", 128'(pulses - p0), 128'd15);

      // Invalid key length
      @(negedge clk);
      p0 = pulses;
      key_len = 2'b11;
      key = KEY128;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("inv_err", 128'(err), 128'd1);
      chk("inv_busy", 128'(busy), 128'd0);
      repeat (10) @(negedge clk);
      chk("inv_no_rk", 128'(pulses - p0), 128'd0);
      chk("inv_err_hold", 128'(err), 128'd1);
      run_key(2'b00, KEY128, 0);
      chk("inv_err_clr", 128'(err), 128'd0);
      chk("inv_then_rk10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("inv_then_done_cyc", 128'(done_cyc - s_cyc - 1), 128'd44);

      // Reset in the middle of an AES-256 run
      @(negedge clk);
      key = KEY256;
      key_len = 2'b10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("rst_mid_rk", rk, 128'h0);
      chk("rst_mid_ctl", 128'({busy, rk_valid, done, err, rk_round}), 128'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("rst_mid_no_done", 128'(done_cnt - d0), 128'd0);
      chk("rst_mid_idle", 128'(busy), 128'd0);

      // Clean restart with a start pulse landing mid-run
      run_key(2'b10, KEY256, 30);
      chk("restart_rk14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
      chk("restart_done_cyc", 128'(done_cyc - s_cyc - 1), 128'd60);
      repeat (70) @(negedge clk);
      chk("restart_pulses", 128'(pulses - p0), 128'd15);
      chk("restart_done_cnt", 128'(done_cnt - d0), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
